// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges system reset requests and stages bus/periph/core release.
// Optional sticky reset-cause register is built when RST_SEQ_CAUSE_EN is defined.
module rst_seq_ctrl #(
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_CYC = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sysresetreq,
    input  logic       wdt_rst_req,
    input  logic       lockup,
    input  logic       boot_chg,
    input  logic       cause_clr,
    output logic       bus_rst_n,
    output logic       periph_rst_n,
    output logic       core_rst_n,
    output logic       rst_busy,
    output logic [4:0] rst_cause
);

    typedef enum logic [1:0] {HOLD, REL_BUS, REL_PERIPH, RUN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       req, req_d1, req_ev;
    logic             ev;

    assign req    = {boot_chg, lockup, wdt_rst_req, sysresetreq};
    assign req_ev = req & ~req_d1;
    assign ev     = |req_ev;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        if (ev) begin
            state_n = HOLD;
            cnt_n   = '0;
        end else begin
            unique case (state)
                HOLD: if (cnt == HOLD_LAST) begin
                    state_n = REL_BUS;
                    cnt_n   = '0;
                end
                REL_BUS: if (cnt == STAGE_LAST) begin
                    state_n = REL_PERIPH;
                    cnt_n   = '0;
                end
                REL_PERIPH: if (cnt == STAGE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
                RUN: cnt_n = '0;
                default: begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // req_d1 resets high so a request held through rst is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HOLD;
            cnt          <= '0;
            req_d1       <= '1;
            bus_rst_n    <= 1'b0;
            periph_rst_n <= 1'b0;
            core_rst_n   <= 1'b0;
            rst_busy     <= 1'b1;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            req_d1       <= req;
            bus_rst_n    <= (state_n != HOLD);
            periph_rst_n <= (state_n == REL_PERIPH) || (state_n == RUN);
            core_rst_n   <= (state_n == RUN);
            rst_busy     <= (state_n != RUN);
        end
    end

`ifdef RST_SEQ_CAUSE_EN
    // A new event together with a clear leaves only the new bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cause <= 5'b00001;
        end else if (ev) begin
            if (cause_clr && state == RUN)
                rst_cause <= {req_ev, 1'b0};
            else
                rst_cause <= rst_cause | {req_ev, 1'b0};
        end else if (cause_clr && state == RUN) begin
            rst_cause <= '0;
        end
    end
`else
    logic unused_cause_clr;
    assign unused_cause_clr = cause_clr;
    assign rst_cause        = '0;
`endif

endmodule
